// File: rtl/io_input_pkg.sv
// Shared constants for the memory-mapped input port: register offsets and
// the default debounce length.
package io_input_pkg;

  localparam logic [1:0] REG_SW      = 2'd0;
  localparam logic [1:0] REG_KEY     = 2'd1;
  localparam logic [1:0] REG_CAPTURE = 2'd2;
  localparam logic [1:0] REG_MASK    = 2'd3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/io_input_port_debounce_bit.sv
// One input bit: two-flop synchronizer, then a stability counter that only
// lets a level through after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_bit
  import io_input_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic flip
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic          synced;
  logic [CW-1:0] cnt;

  // RESET_VAL is the idle level of the raw pin; level is reported relative
  // to idle, so an active-low input comes out inverted (1 = active).
  assign synced = sync ^ RESET_VAL;

  // High on the edge where level is about to change.
  assign flip = (synced != level) && (cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= RESET_VAL;
      sync  <= RESET_VAL;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (synced == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= synced;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped switch/button input port: debounced levels, sticky press
// capture with write-1-to-clear, interrupt mask and a maskable irq.
module io_input_port
  import io_input_pkg::*;
#(
  parameter int NUM_SW          = 10,
  parameter int NUM_KEY         = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SW-1:0]  sw_in,
  input  logic [NUM_KEY-1:0] key_n_in,
  input  logic               sel,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq
);

  logic [NUM_SW-1:0]  sw_lvl;
  logic [NUM_SW-1:0]  sw_flip_unused;
  logic [NUM_KEY-1:0] key_lvl;
  logic [NUM_KEY-1:0] key_flip;
  logic [NUM_KEY-1:0] key_rise;
  logic [NUM_KEY-1:0] capture;
  logic [NUM_KEY-1:0] mask;
  logic [31:0]        rd_mux;
  logic               wr_en;
  logic               unused_wdata;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b0)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw  (sw_in[i]),
      .level(sw_lvl[i]),
      .flip (sw_flip_unused[i])
    );
  end

  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_VAL      (1'b1)
    ) u_db (
      .clock(clock),
      .reset(reset),
      .raw  (key_n_in[i]),
      .level(key_lvl[i]),
      .flip (key_flip[i])
    );
  end

  // Bus protocol: a write is accepted on any rising edge with sel & we high;
  // reads are combinational and return 0 whenever sel is low.
  assign wr_en        = sel && we;
  assign key_rise     = key_flip & ~key_lvl;
  assign unused_wdata = ^wdata;

  // A press completing on the same edge as a clear keeps its flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      capture <= '0;
      mask    <= '0;
    end else begin
      if (wr_en && addr == REG_MASK) begin
        mask <= wdata[NUM_KEY-1:0];
      end
      if (wr_en && addr == REG_CAPTURE) begin
        capture <= (capture & ~wdata[NUM_KEY-1:0]) | key_rise;
      end else begin
        capture <= capture | key_rise;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_SW:      rd_mux[NUM_SW-1:0]  = sw_lvl;
      REG_KEY:     rd_mux[NUM_KEY-1:0] = key_lvl;
      REG_CAPTURE: rd_mux[NUM_KEY-1:0] = capture;
      default:     rd_mux[NUM_KEY-1:0] = mask;
    endcase
  end

  assign rdata = sel ? rd_mux : '0;
  assign irq   = |(capture & mask);

endmodule

// File: tb/tb_io_input_port.sv
// Bench for io_input_port: directed scenarios plus randomized pin/bus
// traffic, all checked against a window-based behavioural model.
module tb_io_input_port;

  localparam int NUM_SW  = 10;
  localparam int NUM_KEY = 4;
  localparam int DC      = 4;
  localparam int NB      = NUM_SW + NUM_KEY;

  logic               clock = 1'b0;
  logic               reset;
  logic [NUM_SW-1:0]  sw_in;
  logic [NUM_KEY-1:0] key_n_in;
  logic               sel;
  logic               we;
  logic [1:0]         addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               irq;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clock = ~clock;

  io_input_port #(
    .NUM_SW         (NUM_SW),
    .NUM_KEY        (NUM_KEY),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .sw_in   (sw_in),
    .key_n_in(key_n_in),
    .sel     (sel),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  // reference model state: levels as {key pressed, sw}, capture, mask
  logic [NB-1:0]      m_lvl;
  logic [NUM_KEY-1:0] m_cap;
  logic [NUM_KEY-1:0] m_mask;
  logic [NB-1:0]      raw_q[$];
  logic [NB-1:0]      sh_q[$];
  logic [31:0]        exp_q[$];

  logic [NUM_SW-1:0]  cur_sw;
  logic [NUM_KEY-1:0] cur_kn;
  logic [31:0]        last_rdata;
  logic               last_irq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic s, input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    if (s) begin
      case (a)
        2'd0:    r[NUM_SW-1:0]  = m_lvl[NUM_SW-1:0];
        2'd1:    r[NUM_KEY-1:0] = m_lvl[NB-1:NUM_SW];
        2'd2:    r[NUM_KEY-1:0] = m_cap;
        default: r[NUM_KEY-1:0] = m_mask;
      endcase
    end
    return r;
  endfunction

  // A level flips once the last DC synchronized samples all disagree with it;
  // the synchronized sample is the pin value seen two edges earlier.
  task automatic model_edge();
    logic [NB-1:0]      synced;
    logic [NB-1:0]      new_lvl;
    logic [NUM_KEY-1:0] rise;
    bit                 all_diff;
    if (reset) begin
      m_lvl  = '0;
      m_cap  = '0;
      m_mask = '0;
      raw_q.delete();
      sh_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      return;
    end
    raw_q.push_back({~key_n_in, sw_in});
    synced = raw_q.pop_front();
    sh_q.push_back(synced);
    if (sh_q.size() > DC) void'(sh_q.pop_front());
    new_lvl = m_lvl;
    if (sh_q.size() == DC) begin
      for (int b = 0; b < NB; b++) begin
        all_diff = 1'b1;
        foreach (sh_q[k]) if (sh_q[k][b] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) new_lvl[b] = ~m_lvl[b];
      end
    end
    rise = new_lvl[NB-1:NUM_SW] & ~m_lvl[NB-1:NUM_SW];
    if (sel && we && addr == 2'd2) m_cap = m_cap & ~wdata[NUM_KEY-1:0];
    if (sel && we && addr == 2'd3) m_mask = wdata[NUM_KEY-1:0];
    m_cap = m_cap | rise;
    m_lvl = new_lvl;
  endtask

  // driver: inputs change on the falling edge, outputs checked 1 time unit later
  task automatic cycle(input logic rst, input logic [NUM_SW-1:0] sw, input logic [NUM_KEY-1:0] kn,
                       input logic s, input logic w, input logic [1:0] a, input logic [31:0] wd);
    @(negedge clock);
    reset    = rst;
    sw_in    = sw;
    key_n_in = kn;
    sel      = s;
    we       = w;
    addr     = a;
    wdata    = wd;
    #1;
    last_rdata = rdata;
    last_irq   = irq;
    exp_q.push_back(model_rdata(s, a));
    check_eq("rdata", rdata, exp_q.pop_front());
    check_eq("irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    @(posedge clock);
    model_edge();
  endtask

  task automatic rd(input logic [1:0] a);
    cycle(1'b0, cur_sw, cur_kn, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cycle(1'b0, cur_sw, cur_kn, 1'b1, 1'b1, a, wd);
  endtask

  initial begin
    logic [NUM_SW-1:0]  t_sw;
    logic [NUM_KEY-1:0] t_kn;
    reset    = 1'b1;
    sw_in    = '0;
    key_n_in = '1;
    sel      = 1'b0;
    we       = 1'b0;
    addr     = 2'd0;
    wdata    = '0;
    model_edge();

    // reset with all switches on and keys released
    cur_sw = 10'h3FF;
    cur_kn = 4'hF;
    for (int a = 0; a < 4; a++) begin
      cycle(1'b1, cur_sw, cur_kn, 1'b1, 1'b0, 2'(a), 32'h0);
      check_eq("rst_rdata", last_rdata, 32'h0);
    end
    check_eq("rst_irq", {31'b0, last_irq}, 32'h0);
    for (int i = 0; i < 6; i++) rd(2'd0);
    check_eq("sw_edge5", last_rdata, 32'h0);
    rd(2'd0);
    check_eq("sw_edge6", last_rdata, 32'h3FF);

    // 3-cycle glitch on key 1
    cur_kn = 4'b1101;
    for (int i = 0; i < 3; i++) rd(2'd1);
    cur_kn = 4'hF;
    for (int i = 0; i < 8; i++) rd(2'd1);
    check_eq("glitch_key", last_rdata, 32'h0);
    rd(2'd2);
    check_eq("glitch_cap", last_rdata, 32'h0);
    check_eq("glitch_irq", {31'b0, last_irq}, 32'h0);

    // key 2 held with its interrupt enabled
    wr(2'd3, 32'h4);
    cur_kn = 4'b1011;
    for (int i = 0; i < 8; i++) rd(2'd2);
    check_eq("cap_key2", last_rdata, 32'h4);
    check_eq("irq_key2", {31'b0, last_irq}, 32'h1);
    rd(2'd1);
    check_eq("lvl_key2", last_rdata, 32'h4);
    cur_kn = 4'hF;
    for (int i = 0; i < 8; i++) rd(2'd2);
    check_eq("cap_release", last_rdata, 32'h4);

    // write-1-to-clear
    wr(2'd2, 32'h0);
    rd(2'd2);
    check_eq("w1c_zero", last_rdata, 32'h4);
    wr(2'd2, 32'h4);
    rd(2'd2);
    check_eq("w1c_clear", last_rdata, 32'h0);
    check_eq("w1c_irq", {31'b0, last_irq}, 32'h0);

    // key 0 finishes debouncing on the same edge as its clear
    cur_kn = 4'b1110;
    for (int i = 0; i < 5; i++) rd(2'd0);
    wr(2'd2, 32'h1);
    rd(2'd2);
    check_eq("set_wins", last_rdata, 32'h1);

    // deselected read, write to read-only offset
    cycle(1'b0, cur_sw, cur_kn, 1'b0, 1'b0, 2'd1, 32'h0);
    check_eq("sel_low", last_rdata, 32'h0);
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0);
    check_eq("sw_ro", last_rdata, 32'h3FF);

    // randomized pins and bus traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_SW; i++) t_sw[i] = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NUM_KEY; i++) t_kn[i] = ($urandom_range(0, 7) == 0);
      cur_sw = cur_sw ^ t_sw;
      cur_kn = cur_kn ^ t_kn;
      cycle(($urandom_range(0, 499) == 0), cur_sw, cur_kn, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/io_input_port.md
Name: io_input_port

Overview:
- Memory-mapped input peripheral for sc_computer: the read-side counterpart of the LED/HEX output ports.
- Synchronizes and debounces the board slide switches (SW) and push-buttons (KEY, active-low).
- Latches button press events in sticky flags and raises a maskable interrupt request.
- Sits on the computer's I/O bus beside the output-port logic, in the CPU clock domain.

Parameters:
- NUM_SW, 10, number of slide-switch inputs (1..32).
- NUM_KEY, 4, number of push-button inputs (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced bit changes (>=1).

Ports:
- clock  in  1  CPU clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- sw_in  in  NUM_SW  raw asynchronous switch levels; 1 = on.
- key_n_in  in  NUM_KEY  raw asynchronous buttons, active-low; 0 = pressed.
- sel  in  1  I/O decode select for this block.
- we  in  1  write strobe, qualified by sel.
- addr  in  2  word offset, driven from bus address bits [3:2].
- wdata  in  32  write data.
- rdata  out  32  read data.
- irq  out  1  interrupt request.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high; all state updates on rising `clock`.
- Reset values:
  - sync flops: sw = 0, key_n = 1 (released).
  - debounced sw_lvl = 0, key_lvl = 0 (key_lvl is 1 = pressed).
  - debounce counters = 0; capture = 0; mask = 0.
  - Outputs: rdata = 0, irq = 0.
- Per-input-bit path:
  - Two-flop synchronizer; key bits are inverted after the synchronizer.
  - Counter cnt, width clog2(DEBOUNCE_CYCLES+1).
  - Each cycle: if synced == stable, then cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1, then stable <= synced and cnt <= 0; else cnt <= cnt+1.
  - Latency: an input step that is held constant appears on stable at edge 2+DEBOUNCE_CYCLES after the edge where it is first sampled.
  - A glitch shorter than DEBOUNCE_CYCLES cycles, after synchronization, never reaches stable. The counter restarts on any return to the stable value.
- Press capture:
  - capture[i] is set on the same edge that key_lvl[i] goes 0->1.
  - Releases (1->0) do not set capture.
  - capture is sticky until cleared by software.
- Register map (addr):
  - 0: SW, read-only; rdata = zero-extended sw_lvl.
  - 1: KEY, read-only; rdata = zero-extended key_lvl.
  - 2: CAPTURE; read returns capture. Write: capture <= capture & ~wdata[NUM_KEY-1:0] (write-1-to-clear).
  - 3: MASK; read and write mask[NUM_KEY-1:0].
  - Writes to offsets 0 and 1 are ignored.
  - Upper unused rdata bits are always 0.
- Read timing:
  - rdata is combinational from registered state, with zero latency, as the single-cycle CPU requires.
  - rdata = 0 whenever sel = 0, so the bus can OR-merge sources.
- Write timing: takes effect on the edge where sel & we = 1.
- irq = |(capture & mask), combinational from registers. It asserts the cycle after the capturing edge, or after an enabling mask write.
- Simultaneous events:
  - If a capture-set and a W1C clear hit the same bit on the same edge, set wins and the bit stays 1.
  - A mask write and a capture-set on the same edge both take effect.
- Reset mid-operation:
  - All counters and flags clear on that edge; partial debounce progress is discarded.
  - An input held pressed through reset is re-debounced afterwards and produces a fresh capture.

Decomposition:
- Package io_input_pkg:
  - register offset constants REG_SW = 0, REG_KEY = 1, REG_CAPTURE = 2, REG_MASK = 3;
  - default DEBOUNCE_CYCLES constant.
- Sub-module debounce_bit:
  - contains the synchronizer, counter and stable flop;
  - parameters DEBOUNCE_CYCLES and RESET_VAL;
  - instantiated NUM_SW+NUM_KEY times via generate.
- Capture, mask, irq and read mux stay in the top module.

Test Plan (sim with DEBOUNCE_CYCLES=4):
- Reset with sw_in=10'h3FF and key_n_in=4'hF held -> rdata=0 at all offsets. SW read at offset 0 becomes 0x3FF exactly at edge 6 after reset release.
- key_n_in[1]=0 for 3 cycles, then back to 1 -> KEY read stays 0, capture stays 0, irq stays 0.
- key_n_in[2]=0 held, mask=4'h4 -> KEY=0x4 and CAPTURE=0x4 at edge 6; irq=1 the following cycle. Releasing does not set a new capture bit.
- Write 0x4 to offset 2 -> CAPTURE=0, irq=0. Write 0x0 instead -> capture unchanged.
- Key press completes debounce on the same edge as a W1C write of that bit -> CAPTURE bit reads 1.
- sel=0 with addr=1 and a key pressed -> rdata=0. Write to offset 0 with wdata=0xFFFFFFFF -> SW read unaffected.
